// File: rtl/minmax_pkg.sv
// Shared definitions for the min/max zero-sequence injection controller:
// FSM encoding, int16 limits, adder width and a saturation helper.
package minmax_pkg;

    // Width of the shared adder: one guard bit above int16.
    localparam int SUM_W = 17;

    localparam logic signed [15:0] INT16_MAX = 16'sh7FFF;
    localparam logic signed [15:0] INT16_MIN = 16'sh8000;

    // FSM state encoding (plain constants so older tools can consume them).
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CMP1  = 3'd1;
    localparam logic [2:0] S_CMP2  = 3'd2;
    localparam logic [2:0] S_OFFS  = 3'd3;
    localparam logic [2:0] S_ADD_A = 3'd4;
    localparam logic [2:0] S_ADD_B = 3'd5;
    localparam logic [2:0] S_ADD_C = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    // Clamp a 17-bit signed value into the int16 range.
    function automatic logic signed [15:0] sat16(input logic signed [SUM_W-1:0] x);
        logic signed [SUM_W-1:0] hi;
        logic signed [SUM_W-1:0] lo;
        hi = {INT16_MAX[15], INT16_MAX};
        lo = {INT16_MIN[15], INT16_MIN};
        if (x > hi) begin
            sat16 = INT16_MAX;
        end else if (x < lo) begin
            sat16 = INT16_MIN;
        end else begin
            sat16 = x[15:0];
        end
    endfunction

endpackage

// File: rtl/minmax_cmp2.sv
// Shared combinational max/min compare. The max lane keeps a_max unless b
// is strictly larger; the min lane keeps a_min unless b is strictly smaller,
// so on a tie the first operand always wins. Feeding a_max = a_min gives a
// plain two-input max/min; feeding a running max/min folds in one new value.
module minmax_cmp2
    import minmax_pkg::*;
(
    input  logic signed [15:0] a_max,
    input  logic signed [15:0] a_min,
    input  logic signed [15:0] b,
    output logic signed [15:0] max_o,
    output logic signed [15:0] min_o
);

    // Pure selection, no state.
    always_comb begin
        max_o = (a_max >= b) ? a_max : b;
        min_o = (a_min <= b) ? a_min : b;
    end

endmodule

// File: rtl/minmax_seq_ctrl.sv
// Sequential SVPWM min/max zero-sequence injector. One compare unit and one
// 17-bit adder are time-shared across an 8-state FSM:
// IDLE -> CMP1 -> CMP2 -> OFFS -> ADD_A -> ADD_B -> ADD_C -> DONE -> IDLE.
module minmax_seq_ctrl
    import minmax_pkg::*;
#(
    parameter int SAT_EN = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [15:0] va,
    input  logic signed [15:0] vb,
    input  logic signed [15:0] vc,
    input  logic               in_valid,
    output logic               in_ready,
    output logic signed [15:0] ma,
    output logic signed [15:0] mb,
    output logic signed [15:0] mc,
    output logic signed [15:0] vmax,
    output logic signed [15:0] vmin,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy
);

    logic [2:0]         state_q, state_d;
    logic signed [15:0] va_q, vb_q, vc_q;
    logic signed [15:0] max_q, min_q;
    logic signed [15:0] vmax_q, vmin_q;
    logic signed [15:0] offset_q;
    logic signed [15:0] ma_q, mb_q, mc_q;

    logic signed [15:0]      cmp_a_max, cmp_a_min, cmp_b;
    logic signed [15:0]      cmp_max, cmp_min;
    logic signed [SUM_W-1:0] add_a, add_b, add_sum;
    logic signed [SUM_W-1:0] half_sum, neg_half;
    logic signed [15:0]      offset_d;
    logic signed [15:0]      add_res;

    // Compare operand routing: va/vb in CMP1, running max/min against vc in CMP2.
    always_comb begin
        cmp_a_max = va_q;
        cmp_a_min = va_q;
        cmp_b     = vb_q;
        if (state_q == S_CMP2) begin
            cmp_a_max = max_q;
            cmp_a_min = min_q;
            cmp_b     = vc_q;
        end
    end

    minmax_cmp2 u_cmp (
        .a_max (cmp_a_max),
        .a_min (cmp_a_min),
        .b     (cmp_b),
        .max_o (cmp_max),
        .min_o (cmp_min)
    );

    // Adder operand routing: vmax+vmin in OFFS, phase+offset in the ADD states.
    always_comb begin
        add_a = '0;
        add_b = '0;
        case (state_q)
            S_OFFS: begin
                add_a = {vmax_q[15], vmax_q};
                add_b = {vmin_q[15], vmin_q};
            end
            S_ADD_A: begin
                add_a = {va_q[15], va_q};
                add_b = {offset_q[15], offset_q};
            end
            S_ADD_B: begin
                add_a = {vb_q[15], vb_q};
                add_b = {offset_q[15], offset_q};
            end
            S_ADD_C: begin
                add_a = {vc_q[15], vc_q};
                add_b = {offset_q[15], offset_q};
            end
            default: begin
                add_a = '0;
                add_b = '0;
            end
        endcase
        add_sum = add_a + add_b;
    end

    // Offset = -floor(sum/2); only +32768 can overflow int16, so it alone is clamped.
    always_comb begin
        half_sum = add_sum >>> 1;
        neg_half = -half_sum;
        if (neg_half > $signed({1'b0, INT16_MAX})) begin
            offset_d = INT16_MAX;
        end else begin
            offset_d = neg_half[15:0];
        end
    end

    // Phase result narrowing: saturate or wrap depending on SAT_EN.
    generate
        if (SAT_EN != 0) begin : g_sat
            always_comb add_res = sat16(add_sum);
        end else begin : g_wrap
            always_comb add_res = add_sum[15:0];
        end
    endgenerate

    // Next-state logic; DONE waits for the consumer and never accepts input.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_CMP1;
            S_CMP1:  state_d = S_CMP2;
            S_CMP2:  state_d = S_OFFS;
            S_OFFS:  state_d = S_ADD_A;
            S_ADD_A: state_d = S_ADD_B;
            S_ADD_B: state_d = S_ADD_C;
            S_ADD_C: state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset wins over every handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            va_q     <= '0;
            vb_q     <= '0;
            vc_q     <= '0;
            max_q    <= '0;
            min_q    <= '0;
            vmax_q   <= '0;
            vmin_q   <= '0;
            offset_q <= '0;
            ma_q     <= '0;
            mb_q     <= '0;
            mc_q     <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        va_q <= va;
                        vb_q <= vb;
                        vc_q <= vc;
                    end
                end
                S_CMP1: begin
                    max_q <= cmp_max;
                    min_q <= cmp_min;
                end
                S_CMP2: begin
                    vmax_q <= cmp_max;
                    vmin_q <= cmp_min;
                end
                S_OFFS:  offset_q <= offset_d;
                S_ADD_A: ma_q <= add_res;
                S_ADD_B: mb_q <= add_res;
                S_ADD_C: mc_q <= add_res;
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign ma        = ma_q;
    assign mb        = mb_q;
    assign mc        = mc_q;
    assign vmax      = vmax_q;
    assign vmin      = vmin_q;

endmodule

// File: tb/tb_minmax_seq_ctrl.sv
// Directed bench for minmax_seq_ctrl: a saturating and a wrapping instance
// share stimulus; expected results are queued at accept and checked at DONE.
module tb_minmax_seq_ctrl;

    typedef struct {
        logic signed [15:0] vmax;
        logic signed [15:0] vmin;
        logic signed [15:0] ma, mb, mc;
        logic signed [15:0] ma_w, mb_w, mc_w;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic signed [15:0] va = '0, vb = '0, vc = '0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;

    logic in_ready, out_valid, busy;
    logic signed [15:0] ma, mb, mc, vmax, vmin;
    logic in_ready_w, out_valid_w, busy_w;
    logic signed [15:0] ma_w, mb_w, mc_w, vmax_w, vmin_w;

    int checks = 0;
    int failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    minmax_seq_ctrl #(.SAT_EN(1)) dut (
        .clk(clk), .reset(reset), .va(va), .vb(vb), .vc(vc),
        .in_valid(in_valid), .in_ready(in_ready),
        .ma(ma), .mb(mb), .mc(mc), .vmax(vmax), .vmin(vmin),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    minmax_seq_ctrl #(.SAT_EN(0)) dut_w (
        .clk(clk), .reset(reset), .va(va), .vb(vb), .vc(vc),
        .in_valid(in_valid), .in_ready(in_ready_w),
        .ma(ma_w), .mb(mb_w), .mc(mc_w), .vmax(vmax_w), .vmin(vmin_w),
        .out_valid(out_valid_w), .out_ready(out_ready), .busy(busy_w)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model in plain integer arithmetic.
    function automatic exp_t model(input int a, input int b, input int c);
        exp_t e;
        int mx, mn, s, off, r;
        int ph[3];
        logic [15:0] w;
        mx = a; if (b > mx) mx = b; if (c > mx) mx = c;
        mn = a; if (b < mn) mn = b; if (c < mn) mn = c;
        s = mx + mn;
        off = -(s >>> 1);
        if (off > 32767) off = 32767;
        e.vmax = 16'(mx);
        e.vmin = 16'(mn);
        ph[0] = a; ph[1] = b; ph[2] = c;
        for (int i = 0; i < 3; i++) begin
            r = ph[i] + off;
            w = r[15:0];
            if (r > 32767) r = 32767;
            if (r < -32768) r = -32768;
            case (i)
                0: begin e.ma = 16'(r); e.ma_w = w; end
                1: begin e.mb = 16'(r); e.mb_w = w; end
                default: begin e.mc = 16'(r); e.mc_w = w; end
            endcase
        end
        return e;
    endfunction

    task automatic check_idle_zero(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 1);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_ma"}, ma, 0);
        chk({tag, "_mb"}, mb, 0);
        chk({tag, "_mc"}, mc, 0);
        chk({tag, "_vmax"}, vmax, 0);
        chk({tag, "_vmin"}, vmin, 0);
    endtask

    // Drive one sample set; bp = cycles of out_ready=0 in DONE; junk toggles
    // in_valid with garbage data while the transaction is in flight.
    task automatic run_txn(input logic signed [15:0] a, input logic signed [15:0] b,
                           input logic signed [15:0] c, input int bp, input bit junk);
        exp_t e;
        int k;
        logic [31:0] r;
        k = 0;
        while (in_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        va = a; vb = b; vc = c;
        in_valid = 1'b1;
        out_ready = (bp == 0);
        sb.push_back(model(a, b, c));
        @(negedge clk);
        if (junk) begin
            r = $urandom;
            va = r[15:0]; vb = r[31:16]; vc = ~r[15:0];
        end else begin
            in_valid = 1'b0;
        end
        k = 1;
        while (out_valid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        $display("txn va=%0d vb=%0d vc=%0d -> vmax=%0d vmin=%0d ma=%0d mb=%0d mc=%0d lat=%0d",
                 a, b, c, vmax, vmin, ma, mb, mc, k);
        chk("latency", k, 7);
        e = sb.pop_front();
        chk("vmax", vmax, e.vmax);
        chk("vmin", vmin, e.vmin);
        chk("ma", ma, e.ma);
        chk("mb", mb, e.mb);
        chk("mc", mc, e.mc);
        chk("ma_wrap", ma_w, e.ma_w);
        chk("mb_wrap", mb_w, e.mb_w);
        chk("mc_wrap", mc_w, e.mc_w);
        chk("done_in_ready", 32'(in_ready), 0);
        if (bp > 0) begin
            for (int i = 1; i < bp; i++) begin
                @(negedge clk);
                chk("bp_out_valid", 32'(out_valid), 1);
                chk("bp_in_ready", 32'(in_ready), 0);
                chk("bp_ma", ma, e.ma);
                chk("bp_vmax", vmax, e.vmax);
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("post_out_valid", 32'(out_valid), 0);
        chk("post_in_ready", 32'(in_ready), 1);
        chk("post_busy", 32'(busy), 0);
        chk("hold_vmin", vmin, e.vmin);
        chk("hold_mc", mc, e.mc);
    endtask

    initial begin
        logic [31:0] r1, r2;
        int k;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_idle_zero("rst");

        run_txn(16'sd1000, -16'sd500, 16'sd200, 0, 1'b0);
        run_txn(16'sd100, 16'sd100, 16'sd100, 0, 1'b0);
        run_txn(16'sh7FFF, 16'sh7FFF, 16'sh8000, 0, 1'b0);
        run_txn(16'sh8000, 16'sh8000, 16'sh8000, 0, 1'b0);
        run_txn(-16'sd3, 16'sd7, 16'sd7, 5, 1'b1);
        run_txn(16'sd5, -16'sd9, 16'sd5, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            r1 = $urandom;
            r2 = $urandom;
            run_txn(r1[15:0], r1[31:16], r2[15:0], i, 1'b0);
        end

        // Abort in ADD_B: accept, advance to T+5, then pulse reset.
        va = 16'sd1234; vb = -16'sd4321; vc = 16'sd77;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (k = 1; k < 5; k++) begin
            chk("abort_no_valid", 32'(out_valid), 0);
            @(negedge clk);
        end
        chk("abort_busy_addb", 32'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        $display("abort reset in ADD_B -> in_ready=%0d busy=%0d out_valid=%0d", in_ready, busy, out_valid);
        check_idle_zero("abort");

        run_txn(16'sd1000, -16'sd500, 16'sd200, 0, 1'b0);
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
